// File: rtl/i2c_apb_job_sequencer.sv
// APB master that runs one I2C write job on the I2C controller's APB port:
// prescale, slave address, payload bytes, START command, then status polling.
module i2c_apb_job_sequencer #(
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter logic [7:0]  CMD_START     = 8'h90,
    parameter int unsigned STAT_BUSY_BIT = 0,
    parameter int unsigned STAT_NACK_BIT = 1,
    parameter int unsigned POLL_GAP      = 16,
    parameter int unsigned POLL_MAX      = 255,
    parameter int unsigned READY_TO      = 64
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       job_valid,
    output logic       job_ready,
    input  logic [7:0] job_prescale,
    input  logic [7:0] job_addr,
    input  logic [3:0] job_len,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       m_PSELx,
    output logic       m_PENABLE,
    output logic       m_PWRITE,
    output logic [7:0] m_PADDR,
    output logic [7:0] m_PWDATA,
    input  logic [7:0] m_PRDATA,
    input  logic       m_PREADY
);

    localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int unsigned TO_W  = (READY_TO > 1) ? $clog2(READY_TO) : 1;

    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(POLL_GAP - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(READY_TO - 1);
    localparam logic [7:0]       POLL_LAST = 8'(POLL_MAX);
    localparam logic [3:0]       LEN_MAX   = 4'(FIFO_DEPTH);

    localparam logic [7:0] A_PRE  = 8'h20;
    localparam logic [7:0] A_ADDR = 8'h40;
    localparam logic [7:0] A_STAT = 8'h60;
    localparam logic [7:0] A_TX   = 8'h80;
    localparam logic [7:0] A_CMD  = 8'hC0;

    typedef enum logic [3:0] {
        S_IDLE, S_W_PRE, S_W_ADDR, S_FETCH, S_W_TX,
        S_W_CMD, S_GAP, S_R_STAT, S_FIN, S_ERR
    } state_t;

    typedef enum logic [1:0] {PH_SETUP, PH_ACCESS, PH_IDLE} phase_t;

    state_t     state_q, state_d, after_xfer;
    phase_t     phase_q, phase_d;
    logic [7:0] pre_q, addr_q, tx_q;
    logic [3:0] len_q, byte_cnt;
    logic [7:0] poll_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic       stat_busy_q, stat_nack_q;
    logic       xfer;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        after_xfer = S_IDLE;
        m_PADDR    = '0;
        m_PWDATA   = '0;

        xfer = (state_q == S_W_PRE) || (state_q == S_W_ADDR) || (state_q == S_W_TX) ||
               (state_q == S_W_CMD) || (state_q == S_R_STAT);

        job_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        tx_ready  = (state_q == S_FETCH);
        done      = (state_q == S_FIN) || (state_q == S_ERR);
        err       = (state_q == S_ERR) || ((state_q == S_FIN) && stat_nack_q);
        m_PSELx   = xfer && (phase_q != PH_IDLE);
        m_PENABLE = xfer && (phase_q == PH_ACCESS);
        m_PWRITE  = m_PSELx && (state_q != S_R_STAT);

        case (state_q)
            S_W_PRE:  begin m_PADDR = A_PRE;  m_PWDATA = pre_q;     end
            S_W_ADDR: begin m_PADDR = A_ADDR; m_PWDATA = addr_q;    end
            S_W_TX:   begin m_PADDR = A_TX;   m_PWDATA = tx_q;      end
            S_W_CMD:  begin m_PADDR = A_CMD;  m_PWDATA = CMD_START; end
            S_R_STAT: m_PADDR = A_STAT;
            default:  ;
        endcase

        // Successor of each APB transfer, taken after its trailing idle cycle.
        case (state_q)
            S_W_PRE:  after_xfer = S_W_ADDR;
            S_W_ADDR: after_xfer = (len_q == '0) ? S_W_CMD : S_FETCH;
            S_W_TX:   after_xfer = (byte_cnt == len_q) ? S_W_CMD : S_FETCH;
            S_W_CMD:  after_xfer = S_GAP;
            S_R_STAT: after_xfer = !stat_busy_q ? S_FIN :
                                   (poll_cnt == POLL_LAST) ? S_ERR : S_GAP;
            default:  after_xfer = S_IDLE;
        endcase

        case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    state_d = (job_len > LEN_MAX) ? S_ERR : S_W_PRE;
                    phase_d = PH_SETUP;
                end
            end
            S_FETCH: begin
                if (tx_valid) begin
                    state_d = S_W_TX;
                    phase_d = PH_SETUP;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_d = S_R_STAT;
                    phase_d = PH_SETUP;
                end
            end
            S_FIN, S_ERR: begin
                state_d = S_IDLE;
                phase_d = PH_SETUP;
            end
            default: begin
                case (phase_q)
                    PH_SETUP: phase_d = PH_ACCESS;
                    PH_ACCESS: begin
                        if (m_PREADY) begin
                            phase_d = PH_IDLE;
                        end else if (to_cnt == TO_LAST) begin
                            state_d = S_ERR;
                            phase_d = PH_SETUP;
                        end
                    end
                    default: begin
                        state_d = after_xfer;
                        phase_d = PH_SETUP;
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_SETUP;
            pre_q       <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            tx_q        <= '0;
            byte_cnt    <= '0;
            poll_cnt    <= '0;
            gap_cnt     <= '0;
            to_cnt      <= '0;
            stat_busy_q <= 1'b0;
            stat_nack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;

            if ((state_q == S_IDLE) && job_valid) begin
                pre_q    <= job_prescale;
                addr_q   <= job_addr;
                len_q    <= job_len;
                byte_cnt <= '0;
                poll_cnt <= '0;
            end

            if ((state_q == S_FETCH) && tx_valid) begin
                tx_q <= tx_data;
            end

            if (m_PENABLE && !m_PREADY && (to_cnt != TO_LAST)) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end

            if ((state_q == S_GAP) && (gap_cnt != GAP_LAST)) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end

            if ((state_q == S_W_TX) && m_PENABLE && m_PREADY) begin
                byte_cnt <= byte_cnt + 1'b1;
            end

            if ((state_q == S_R_STAT) && m_PENABLE && m_PREADY) begin
                stat_busy_q <= m_PRDATA[STAT_BUSY_BIT];
                stat_nack_q <= m_PRDATA[STAT_NACK_BIT];
                if (poll_cnt != POLL_LAST) begin
                    poll_cnt <= poll_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_apb_job_sequencer.sv
// Bench for i2c_apb_job_sequencer: APB slave model with a transfer log, a payload
// feeder, and a job-level reference model of the expected APB traffic.
module tb_i2c_apb_job_sequencer;

    localparam int FIFO_DEPTH = 8;
    localparam int POLL_MAX   = 255;
    localparam int READY_TO   = 64;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;

    logic       PCLK, PRESET;
    logic       job_valid, job_ready;
    logic [7:0] job_prescale, job_addr;
    logic [3:0] job_len;
    logic       tx_valid, tx_ready;
    logic [7:0] tx_data;
    logic       busy, done, err;
    logic       m_PSELx, m_PENABLE, m_PWRITE;
    logic [7:0] m_PADDR, m_PWDATA, m_PRDATA;
    logic       m_PREADY;

    int checks = 0;
    int errors = 0;

    txn_t got_q[$];
    txn_t exp_q[$];

    i2c_apb_job_sequencer dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_prescale(job_prescale), .job_addr(job_addr), .job_len(job_len),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .busy(busy), .done(done), .err(err),
        .m_PSELx(m_PSELx), .m_PENABLE(m_PENABLE), .m_PWRITE(m_PWRITE),
        .m_PADDR(m_PADDR), .m_PWDATA(m_PWDATA), .m_PRDATA(m_PRDATA), .m_PREADY(m_PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // APB slave: protocol checks, PREADY after ready_delay ACCESS cycles (-1 = never).
    int         ready_delay = 0;
    logic [7:0] status_q[$];
    logic [7:0] status_def = 8'h00;
    int         setup_cnt = 0;
    int         last_acc = 0;
    int         acc_n = 0;
    bit         in_xfer = 1'b0;
    bit         prev_psel = 1'b0;
    logic       s_wr;
    logic [7:0] s_addr, s_data;

    initial begin
        logic [7:0] d;
        m_PREADY = 1'b0;
        m_PRDATA = 8'h00;
        forever begin
            @(negedge PCLK);
            if (tx_ready) check("apb_idle_in_fetch", m_PSELx, 0);
            if (m_PSELx && !m_PENABLE) begin
                check("idle_before_setup", prev_psel, 0);
                setup_cnt++;
                in_xfer = 1'b1;
                acc_n   = 0;
                s_wr    = m_PWRITE;
                s_addr  = m_PADDR;
                s_data  = m_PWDATA;
                m_PREADY = 1'b0;
            end else if (m_PSELx && m_PENABLE) begin
                check("setup_before_access", in_xfer, 1);
                acc_n++;
                last_acc = acc_n;
                check("paddr_stable", m_PADDR, s_addr);
                check("pwrite_stable", m_PWRITE, s_wr);
                if (s_wr) check("pwdata_stable", m_PWDATA, s_data);
                if (ready_delay >= 0 && acc_n > ready_delay) begin
                    m_PREADY = 1'b1;
                    if (s_wr) begin
                        d = s_data;
                    end else begin
                        d = (status_q.size() > 0) ? status_q.pop_front() : status_def;
                        m_PRDATA = d;
                    end
                    got_q.push_back(txn_t'({s_wr, s_addr, d}));
                    in_xfer = 1'b0;
                end else begin
                    m_PREADY = 1'b0;
                end
            end else begin
                m_PREADY = 1'b0;
                in_xfer  = 1'b0;
            end
            prev_psel = m_PSELx;
        end
    end

    // Payload feeder: presents queued bytes with random idle gaps.
    logic [7:0] feed_q[$];
    int gap_max = 0;
    int gap_left = 0;
    bit hs_pend = 1'b0;

    initial begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        forever begin
            @(negedge PCLK);
            if (hs_pend) begin
                tx_valid = 1'b0;
                if (feed_q.size() > 0) void'(feed_q.pop_front());
                gap_left = $urandom_range(gap_max, 0);
            end
            if (tx_valid && feed_q.size() == 0) tx_valid = 1'b0;
            if (!tx_valid && feed_q.size() > 0) begin
                if (gap_left > 0) gap_left--;
                else begin
                    tx_valid = 1'b1;
                    tx_data  = feed_q[0];
                end
            end
            hs_pend = tx_valid && tx_ready && !PRESET;
        end
    end

    // Reference model: APB traffic and error outcome of one job.
    function automatic bit build_exp(input logic [7:0] pre, input logic [7:0] addr,
                                     input logic [7:0] bytes[$], input int len,
                                     input logic [7:0] stats[$], input logic [7:0] sdef);
        logic [7:0] s;
        exp_q.delete();
        if (len > FIFO_DEPTH) return 1'b1;
        exp_q.push_back(txn_t'({1'b1, 8'h20, pre}));
        exp_q.push_back(txn_t'({1'b1, 8'h40, addr}));
        foreach (bytes[i]) exp_q.push_back(txn_t'({1'b1, 8'h80, bytes[i]}));
        exp_q.push_back(txn_t'({1'b1, 8'hC0, 8'h90}));
        for (int n = 1; n <= POLL_MAX; n++) begin
            s = (n <= stats.size()) ? stats[n-1] : sdef;
            exp_q.push_back(txn_t'({1'b0, 8'h60, s}));
            if (!s[0]) return s[1];
        end
        return 1'b1;
    endfunction

    task automatic run_job(input string tag, input logic [7:0] pre, input logic [7:0] addr,
                           input logic [3:0] len, input bit exp_err, input int limit,
                           output int cyc);
        got_q.delete();
        @(negedge PCLK);
        check({tag, "_ready"}, job_ready, 1);
        job_prescale = pre;
        job_addr     = addr;
        job_len      = len;
        job_valid    = 1'b1;
        @(negedge PCLK);
        job_valid = 1'b0;
        check({tag, "_busy"}, busy, 1);
        cyc = 0;
        while (!done && cyc < limit) begin
            @(negedge PCLK);
            cyc++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_err"}, err, exp_err);
        @(negedge PCLK);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_ready_after"}, job_ready, 1);
        check({tag, "_ntxn"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_txn"}, 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        logic [7:0] bytes[$];
        logic [7:0] stats[$];
        logic [7:0] pre, addr;
        bit e;
        int cyc, len, sc;

        PRESET = 1'b1;
        job_valid = 1'b0;
        job_prescale = 8'h00;
        job_addr = 8'h00;
        job_len = 4'h0;
        repeat (3) @(negedge PCLK);
        check("rst_job_ready", job_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_psel", m_PSELx, 0);
        check("rst_penable", m_PENABLE, 0);
        check("rst_pwrite", m_PWRITE, 0);
        check("rst_paddr", m_PADDR, 0);
        check("rst_pwdata", m_PWDATA, 0);
        check("rst_tx_ready", tx_ready, 0);
        PRESET = 1'b0;

        // Basic single-byte job with two busy polls.
        bytes = '{8'h01};
        stats = '{8'h01, 8'h01, 8'h00};
        status_q = stats;
        feed_q = bytes;
        e = build_exp(8'h04, 8'h20, bytes, 1, stats, status_def);
        check("t1_model_reads", exp_q.size(), 7);
        run_job("t1", 8'h04, 8'h20, 4'd1, e, 2000, cyc);

        // Full FIFO with gapped payload.
        gap_max = 5;
        bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        stats.delete();
        repeat ($urandom_range(3, 0)) stats.push_back(8'h01 | 8'($urandom & 32'hFE));
        stats.push_back(8'($urandom & 32'hFE));
        status_q = stats;
        feed_q = bytes;
        pre = 8'($urandom);
        addr = 8'($urandom);
        e = build_exp(pre, addr, bytes, 8, stats, status_def);
        run_job("t2", pre, addr, 4'd8, e, 3000, cyc);

        // Slow PREADY.
        gap_max = 0;
        ready_delay = 3;
        bytes = '{8'hA5, 8'h3C};
        stats = '{8'h00};
        status_q = stats;
        feed_q = bytes;
        e = build_exp(8'h11, 8'h22, bytes, 2, stats, status_def);
        run_job("t3", 8'h11, 8'h22, 4'd2, e, 3000, cyc);
        check("t3_access_len", last_acc, 4);

        // PREADY never arrives.
        ready_delay = -1;
        exp_q.delete();
        run_job("t3to", 8'h33, 8'h44, 4'd0, 1'b1, 500, cyc);
        check("t3to_cycles", cyc, READY_TO + 1);
        check("t3to_access_len", last_acc, READY_TO);
        ready_delay = 0;

        // NACK on final status.
        bytes = '{8'h77};
        stats = '{8'h02};
        status_q = stats;
        feed_q = bytes;
        e = build_exp(8'h05, 8'h50, bytes, 1, stats, status_def);
        run_job("t4nack", 8'h05, 8'h50, 4'd1, e, 2000, cyc);

        // Status stuck busy until poll limit.
        status_def = 8'h01;
        stats.delete();
        status_q.delete();
        bytes.delete();
        e = build_exp(8'h06, 8'h60, bytes, 0, stats, status_def);
        check("t4stuck_model_err", e, 1);
        run_job("t4stuck", 8'h06, 8'h60, 4'd0, e, 8000, cyc);
        status_def = 8'h00;

        // Oversized job is rejected without APB traffic.
        sc = setup_cnt;
        e = build_exp(8'h07, 8'h70, bytes, 9, stats, status_def);
        run_job("t5rej", 8'h07, 8'h70, 4'd9, e, 10, cyc);
        check("t5rej_cycles", cyc, 0);
        check("t5rej_no_psel", setup_cnt - sc, 0);

        // Address-only job.
        stats = '{8'h01, 8'h00};
        status_q = stats;
        e = build_exp(8'h08, 8'h80, bytes, 0, stats, status_def);
        run_job("t5zero", 8'h08, 8'h80, 4'd0, e, 2000, cyc);

        // Reset in the middle of a payload write.
        ready_delay = 3;
        feed_q = '{8'h5A};
        @(negedge PCLK);
        job_prescale = 8'h09;
        job_addr = 8'h90;
        job_len = 4'd1;
        job_valid = 1'b1;
        @(negedge PCLK);
        job_valid = 1'b0;
        cyc = 0;
        while (!(m_PENABLE && m_PADDR == 8'h80) && cyc < 200) begin
            @(negedge PCLK);
            cyc++;
        end
        check("t6_reached_wtx", m_PENABLE && m_PADDR == 8'h80, 1);
        PRESET = 1'b1;
        #1;
        check("t6_psel", m_PSELx, 0);
        check("t6_penable", m_PENABLE, 0);
        check("t6_job_ready", job_ready, 1);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_err", err, 0);
        feed_q.delete();
        @(negedge PCLK);
        @(negedge PCLK);
        check("t6_done_held", done, 0);
        PRESET = 1'b0;
        ready_delay = 0;
        bytes = '{8'hC3};
        stats = '{8'h01, 8'h00};
        status_q = stats;
        feed_q = bytes;
        e = build_exp(8'h0A, 8'hA0, bytes, 1, stats, status_def);
        run_job("t6after", 8'h0A, 8'hA0, 4'd1, e, 2000, cyc);

        // Random jobs.
        gap_max = 3;
        for (int j = 0; j < 3; j++) begin
            ready_delay = $urandom_range(2, 0);
            len = $urandom_range(FIFO_DEPTH, 0);
            bytes.delete();
            for (int k = 0; k < len; k++) bytes.push_back(8'($urandom));
            stats.delete();
            repeat ($urandom_range(2, 0)) stats.push_back(8'h01 | 8'($urandom & 32'hFE));
            stats.push_back(8'($urandom & 32'hFE));
            status_q = stats;
            feed_q = bytes;
            pre = 8'($urandom);
            addr = 8'($urandom);
            e = build_exp(pre, addr, bytes, len, stats, status_def);
            run_job("rnd", pre, addr, 4'(len), e, 4000, cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
